mm_row_load_ctrl: RTL and testbench

//  Sequencer for the 10x16-bit row register bank of the matrix-multiply datapath.
//  - Fetches ROWS rows of LANES elements from operand memory into an internal assembly buffer.
//  - Pulses the bank's ld with the assembled 160-bit row.
//  - Offers each loaded row to the MAC array with a valid/ack handshake.
//  - Fetches the next row while the current one is in use, so it overlaps compute.

---
 rtl/mm_row_load_ctrl.sv | 145 ++++++++++++++
 tb/tb_mm_row_load_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mm_row_load_ctrl.sv
// Row fetch/load sequencer for the matrix-multiply row register bank.
// Assembles one row from operand memory while the MAC array consumes the previous one.
module mm_row_load_ctrl #(
  parameter int ELEM_W = 16,
  parameter int LANES  = 10,
  parameter int ROWS   = 10,
  parameter int ADDR_W = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      start_i,
  input  logic                      abort_i,
  input  logic [ADDR_W-1:0]         base_addr_i,
  output logic                      mem_rd_o,
  output logic [ADDR_W-1:0]         mem_addr_o,
  input  logic [ELEM_W-1:0]         mem_rdata_i,
  output logic                      ld_o,
  output logic [LANES*ELEM_W-1:0]   row_data_o,
  output logic                      row_valid_o,
  input  logic                      row_ack_i,
  output logic [3:0]                row_idx_o,
  output logic                      busy_o,
  output logic                      done_o
);

  localparam int LANE_W = $clog2(LANES + 1);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT_SLOT, LOAD, DRAIN} state_e;

  state_e                          state_q, state_d;
  logic [LANE_W-1:0]               lane_q, lane_d;
  logic [3:0]                      row_q, row_d;
  logic [ADDR_W-1:0]               rowBase_q, rowBase_d;
  logic                            slotFree_q, slotFree_d;
  logic                            done_q, done_d;
  logic                            rdPend_q;
  logic [LANE_W-1:0]               rdLane_q;
  logic [LANES-1:0][ELEM_W-1:0]    rowBuf_q;
  logic [LANES*ELEM_W-1:0]         rowData_q;
  logic [3:0]                      rowIdx_q;
  logic                            memRd, ldPulse, ackFire, freeNow;

  assign busy_o      = (state_q != IDLE);
  assign row_valid_o = busy_o & ~slotFree_q;
  assign ackFire     = row_valid_o & row_ack_i;
  // The slot counts as free in the same cycle it is acked so the next ld lands at ack+1.
  assign freeNow     = slotFree_q | ackFire;

  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    row_d      = row_q;
    rowBase_d  = rowBase_q;
    slotFree_d = slotFree_q;
    done_d     = 1'b0;
    memRd      = 1'b0;
    ldPulse    = 1'b0;
    if (ackFire) slotFree_d = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          rowBase_d  = base_addr_i;
          row_d      = '0;
          lane_d     = '0;
          slotFree_d = 1'b1;
          state_d    = FETCH;
        end
      end
      FETCH: begin
        if (lane_q != LANE_W'(LANES)) begin
          memRd  = 1'b1;
          lane_d = lane_q + LANE_W'(1);
        end else begin
          state_d = freeNow ? LOAD : WAIT_SLOT;
        end
      end
      WAIT_SLOT: begin
        if (freeNow) state_d = LOAD;
      end
      LOAD: begin
        ldPulse    = 1'b1;
        slotFree_d = 1'b0;
        if (row_q != 4'(ROWS - 1)) begin
          row_d     = row_q + 4'd1;
          lane_d    = '0;
          rowBase_d = rowBase_q + ADDR_W'(LANES);
          state_d   = FETCH;
        end else begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (ackFire) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort_i && state_q != IDLE) begin
      state_d    = IDLE;
      slotFree_d = 1'b1;
      done_d     = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      lane_q     <= '0;
      row_q      <= '0;
      rowBase_q  <= '0;
      slotFree_q <= 1'b1;
      done_q     <= 1'b0;
      rdPend_q   <= 1'b0;
      rdLane_q   <= '0;
      rowBuf_q   <= '0;
      rowData_q  <= '0;
      rowIdx_q   <= '0;
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      row_q      <= row_d;
      rowBase_q  <= rowBase_d;
      slotFree_q <= slotFree_d;
      done_q     <= done_d;
      rdPend_q   <= memRd;
      rdLane_q   <= lane_q;
      // Read data trails its strobe by one cycle, so write the lane captured with it.
      if (rdPend_q) rowBuf_q[rdLane_q] <= mem_rdata_i;
      if (ldPulse) begin
        rowData_q <= rowBuf_q;
        rowIdx_q  <= row_q;
      end
    end
  end

  assign mem_rd_o   = memRd;
  assign mem_addr_o = memRd ? rowBase_q + ADDR_W'(lane_q) : '0;
  assign ld_o       = ldPulse;
  assign row_data_o = (state_q == LOAD) ? rowBuf_q : rowData_q;
  assign row_idx_o  = (state_q == LOAD) ? row_q : rowIdx_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_mm_row_load_ctrl.sv
// Directed bench for mm_row_load_ctrl: memory model returns mem[a]=a one cycle after each read,
// and a small acker consumes rows one cycle after row_valid rises.
module tb_mm_row_load_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start, abort;
  logic [7:0]   base_addr;
  logic         mem_rd;
  logic [7:0]   mem_addr;
  logic [15:0]  mem_rdata;
  logic         ld;
  logic [159:0] row_data;
  logic         row_valid;
  logic         row_ack;
  logic [3:0]   row_idx;
  logic         busy;
  logic         done;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int startCyc;
  int rdCount, ldCount, doneCount;
  logic autoAck, spurAck, rdPrev, prevValid, found;
  logic [7:0] addrPrev;
  logic [7:0] rdAddr [$];
  logic [159:0] capData [16];
  logic [3:0] capIdx [16];
  int ldCyc [16];

  always #5 clk = ~clk;

  mm_row_load_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
    .base_addr_i(base_addr), .mem_rd_o(mem_rd), .mem_addr_o(mem_addr),
    .mem_rdata_i(mem_rdata), .ld_o(ld), .row_data_o(row_data),
    .row_valid_o(row_valid), .row_ack_i(row_ack), .row_idx_o(row_idx),
    .busy_o(busy), .done_o(done)
  );

  task automatic checkOutput(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: answer last cycle's read, log this cycle's outputs, drive the acker.
  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
    mem_rdata = rdPrev ? {8'h00, addrPrev} : 16'hDEAD;
    rdPrev = mem_rd;
    addrPrev = mem_addr;
    if (mem_rd) begin
      rdCount++;
      rdAddr.push_back(mem_addr);
    end
    if (ld && ldCount < 16) begin
      capData[ldCount] = row_data;
      capIdx[ldCount] = row_idx;
      ldCyc[ldCount] = cyc;
    end
    if (ld) ldCount++;
    if (done) doneCount++;
    if (autoAck) row_ack = row_valid ? prevValid : spurAck;
    prevValid = row_valid;
  endtask

  task automatic clearLog;
    rdCount = 0;
    ldCount = 0;
    doneCount = 0;
    rdAddr.delete();
    prevValid = 1'b0;
    rdPrev = 1'b0;
    for (int i = 0; i < 16; i++) begin
      capData[i] = '0;
      capIdx[i] = '0;
      ldCyc[i] = 0;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    base_addr = b;
    start = 1'b1;
    startCyc = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int budget);
    int n = 0;
    while (doneCount == 0 && n < budget) begin
      tick();
      n++;
    end
    checkOutput(tag, 160'(doneCount != 0), 160'(1));
  endtask

  function automatic logic [159:0] expRow(input logic [7:0] b, input int r);
    logic [159:0] v;
    logic [7:0] a;
    v = '0;
    for (int k = 0; k < 10; k++) begin
      a = b + 8'(r * 10 + k);
      v[k*16 +: 16] = {8'h00, a};
    end
    return v;
  endfunction

  // Full-speed pass: ld for row r lands 12*(r+1) cycles after start is sampled.
  task automatic checkPass(input string p, input logic [7:0] b);
    checkOutput({p, "_ld_count"}, 160'(ldCount), 160'(10));
    checkOutput({p, "_rd_count"}, 160'(rdCount), 160'(100));
    for (int r = 0; r < 10; r++) begin
      checkOutput($sformatf("%s_row%0d_data", p, r), capData[r], expRow(b, r));
      checkOutput($sformatf("%s_row%0d_idx", p, r), 160'(capIdx[r]), 160'(r));
      checkOutput($sformatf("%s_row%0d_ldcyc", p, r), 160'(ldCyc[r] - startCyc), 160'(12 * (r + 1)));
    end
  endtask

  task automatic checkIdleAfter(input string p);
    repeat (3) tick();
    checkOutput({p, "_done_once"}, 160'(doneCount), 160'(1));
    checkOutput({p, "_busy_end"}, 160'(busy), 160'(0));
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    base_addr = '0;
    row_ack = 1'b0;
    mem_rdata = '0;
    autoAck = 1'b0;
    spurAck = 1'b0;
    found = 1'b0;
    clearLog();
    #12;
    checkOutput("rst_busy", 160'(busy), 160'(0));
    checkOutput("rst_mem_rd", 160'(mem_rd), 160'(0));
    checkOutput("rst_mem_addr", 160'(mem_addr), 160'(0));
    checkOutput("rst_ld", 160'(ld), 160'(0));
    checkOutput("rst_row_valid", 160'(row_valid), 160'(0));
    checkOutput("rst_row_data", row_data, 160'(0));
    checkOutput("rst_row_idx", 160'(row_idx), 160'(0));
    checkOutput("rst_done", 160'(done), 160'(0));
    tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] scenario 1: base 0x00, prompt acks");
    clearLog();
    autoAck = 1'b1;
    applyStimulus(8'h00);
    checkOutput("s1_first_addr", 160'(mem_addr), 160'(8'h00));
    checkOutput("s1_busy", 160'(busy), 160'(1));
    waitDone("s1_done_seen", 400);
    checkPass("s1", 8'h00);
    checkIdleAfter("s1");

    $display("[TB] scenario 2: ack withheld 40 cycles");
    clearLog();
    autoAck = 1'b0;
    row_ack = 1'b0;
    applyStimulus(8'h20);
    found = 1'b0;
    for (int n = 0; n < 50 && !found; n++) begin
      if (row_valid) found = 1'b1;
      else tick();
    end
    checkOutput("s2_valid_seen", 160'(found), 160'(1));
    repeat (40) tick();
    checkOutput("s2_ld_held", 160'(ldCount), 160'(1));
    checkOutput("s2_rd_count", 160'(rdCount), 160'(20));
    checkOutput("s2_data_held", row_data, expRow(8'h20, 0));
    checkOutput("s2_valid_held", 160'(row_valid), 160'(1));
    checkOutput("s2_no_ld_now", 160'(ld), 160'(0));
    row_ack = 1'b1;
    tick();
    row_ack = 1'b0;
    checkOutput("s2_ld_after_ack", 160'(ld), 160'(1));
    checkOutput("s2_idx_after_ack", 160'(row_idx), 160'(1));
    checkOutput("s2_data_after_ack", row_data, expRow(8'h20, 1));
    autoAck = 1'b1;
    prevValid = 1'b0;
    waitDone("s2_done_seen", 400);
    checkOutput("s2_ld_total", 160'(ldCount), 160'(10));
    checkOutput("s2_row9_data", capData[9], expRow(8'h20, 9));

    $display("[TB] scenario 3: base 0xFA wraps");
    clearLog();
    applyStimulus(8'hFA);
    waitDone("s3_done_seen", 400);
    for (int i = 0; i < 20; i++) begin
      logic [7:0] e;
      e = 8'hFA + 8'(i);
      checkOutput($sformatf("s3_addr%0d", i), 160'(rdAddr[i]), 160'(e));
    end
    checkOutput("s3_row0_data", capData[0], expRow(8'hFA, 0));
    checkOutput("s3_row1_data", capData[1], expRow(8'hFA, 1));

    $display("[TB] scenario 4: abort at row 3 lane 5");
    clearLog();
    applyStimulus(8'h40);
    found = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      if (mem_rd && mem_addr == 8'h63) found = 1'b1;
      else tick();
    end
    checkOutput("s4_lane5_seen", 160'(found), 160'(1));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("s4_busy", 160'(busy), 160'(0));
    checkOutput("s4_mem_rd", 160'(mem_rd), 160'(0));
    checkOutput("s4_row_valid", 160'(row_valid), 160'(0));
    checkOutput("s4_done", 160'(done), 160'(0));
    repeat (5) tick();
    checkOutput("s4_no_done", 160'(doneCount), 160'(0));
    checkOutput("s4_ld_count", 160'(ldCount), 160'(3));
    clearLog();
    applyStimulus(8'h80);
    checkOutput("s4_restart_rd", 160'(mem_rd), 160'(1));
    checkOutput("s4_restart_addr", 160'(mem_addr), 160'(8'h80));
    waitDone("s4_done_seen", 400);
    checkPass("s4", 8'h80);

    $display("[TB] scenario 5: async reset mid-fetch of row 2");
    clearLog();
    applyStimulus(8'h10);
    found = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      if (mem_rd && mem_addr == 8'h27) found = 1'b1;
      else tick();
    end
    checkOutput("s5_row2_seen", 160'(found), 160'(1));
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("s5_busy", 160'(busy), 160'(0));
    checkOutput("s5_mem_rd", 160'(mem_rd), 160'(0));
    checkOutput("s5_mem_addr", 160'(mem_addr), 160'(0));
    checkOutput("s5_ld", 160'(ld), 160'(0));
    checkOutput("s5_row_valid", 160'(row_valid), 160'(0));
    checkOutput("s5_row_data", row_data, 160'(0));
    checkOutput("s5_row_idx", 160'(row_idx), 160'(0));
    checkOutput("s5_done", 160'(done), 160'(0));
    tick();
    rst_n = 1'b1;
    clearLog();
    applyStimulus(8'h00);
    waitDone("s5_done_seen", 400);
    checkPass("s5", 8'h00);

    $display("[TB] scenario 6: start held, stray acks");
    clearLog();
    spurAck = 1'b1;
    base_addr = 8'h00;
    start = 1'b1;
    startCyc = cyc;
    tick();
    for (int n = 0; n < 200 && ldCount < 10; n++) tick();
    start = 1'b0;
    waitDone("s6_done_seen", 100);
    spurAck = 1'b0;
    checkPass("s6", 8'h00);
    row_ack = 1'b0;
    checkIdleAfter("s6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
